// File: rtl/ntt_arith_pkg.sv
// Shared arithmetic definitions for the NTT modular datapath: default modulus,
// table-geometry check and the add/sub mode encoding.
package ntt_arith_pkg;

    localparam int unsigned NTT_DEFAULT_Q = 32'd1073479681;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    // Table must be a power of two with at least two entries addressed by exactly idx_w bits.
    function automatic bit idx_w_consistent(input int num_mods, input int idx_w);
        return (num_mods >= 2) && ((1 << idx_w) == num_mods);
    endfunction

endpackage

// File: rtl/mod_addsub_pipe_if.sv
// Configuration, operation and result bus of mod_addsub_pipe; slave is the block side.
interface mod_addsub_pipe_if #(
    parameter int W     = 30,
    parameter int IDX_W = 4,
    parameter int TAG_W = 8
);
    logic             cfg_we;
    logic [IDX_W-1:0] cfg_addr;
    logic [W-1:0]     cfg_q;
    logic             mod_sel;
    logic [IDX_W-1:0] mod_index;
    logic             in_valid;
    logic             in_ready;
    logic             in_sub;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_c;
    logic [TAG_W-1:0] out_tag;
    logic             err;

    modport master (
        output cfg_we, cfg_addr, cfg_q, mod_sel, mod_index,
        output in_valid, in_sub, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_c, out_tag, err
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_q, mod_sel, mod_index,
        input  in_valid, in_sub, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_c, out_tag, err
    );
endinterface

// File: rtl/mod_addsub_pipe_table.sv
// Modulus register file: one synchronous write port, one asynchronous read port,
// every entry resets to DEFAULT_Q.
module mod_table #(
    parameter int             W         = 30,
    parameter int             NUM_MODS  = 16,
    parameter int             IDX_W     = 4,
    parameter logic [W-1:0]   DEFAULT_Q = W'(32'd1073479681)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [W-1:0]     wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [W-1:0]     rdata
);
    logic [W-1:0] mem [NUM_MODS];

    for (genvar i = 0; i < NUM_MODS; i++) begin : g_ent
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                mem[i] <= DEFAULT_Q;
            else if (we && waddr == IDX_W'(i))
                mem[i] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/mod_addsub_pipe.sv
// Two-stage elastic modular adder/subtractor with a writable modulus table.
// Define MOD_ADDSUB_RANGE_CHECK_EN to build the sticky operand range-error flag.
module mod_addsub_pipe
    import ntt_arith_pkg::*;
#(
    parameter int           W         = 30,
    parameter int           NUM_MODS  = 16,
    parameter int           IDX_W     = 4,
    parameter int           TAG_W     = 8,
    parameter logic [W-1:0] DEFAULT_Q = W'(NTT_DEFAULT_Q)
) (
    input logic              clk,
    input logic              rst_n,
    mod_addsub_pipe_if.slave bus
);
    localparam int STAGES = 2;

    if (!idx_w_consistent(NUM_MODS, IDX_W)) begin : g_cfg_err
        $error("mod_addsub_pipe: IDX_W must equal log2(NUM_MODS)");
    end

    logic [STAGES:1]  vld_pipe;
    logic             s1_adv, s2_adv, accept;
    logic [IDX_W-1:0] act_idx;
    logic [W-1:0]     q_sel;

    logic [W:0]       raw;
    mode_e            mode_in;
    logic [W:0]       s1_r;
    logic [W-1:0]     s1_q;
    mode_e            s1_mode;
    logic [TAG_W-1:0] s1_tag;

    logic [W:0]       q_ext;
    logic [W-1:0]     c_next;
    logic [W-1:0]     s2_c;
    logic [TAG_W-1:0] s2_tag;

    mod_table #(
        .W(W), .NUM_MODS(NUM_MODS), .IDX_W(IDX_W), .DEFAULT_Q(DEFAULT_Q)
    ) u_table (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (bus.cfg_we),
        .waddr (bus.cfg_addr),
        .wdata (bus.cfg_q),
        .raddr (act_idx),
        .rdata (q_sel)
    );

    assign s2_adv       = !vld_pipe[2] || bus.out_ready;
    assign s1_adv       = !vld_pipe[1] || s2_adv;
    assign bus.in_ready = rst_n && s1_adv;
    assign accept       = bus.in_valid && bus.in_ready;

    // Same-edge mod_sel/accept: the op reads q through the old index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            act_idx <= '0;
        else if (bus.mod_sel)
            act_idx <= bus.mod_index;
    end

    // Sub result is two's complement on W+1 bits; bit W flags a negative difference.
    assign mode_in = mode_e'(bus.in_sub);
    assign raw     = (mode_in == MODE_SUB) ? ({1'b0, bus.in_a} - {1'b0, bus.in_b})
                                           : ({1'b0, bus.in_a} + {1'b0, bus.in_b});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe[1] <= 1'b0;
            s1_r        <= '0;
            s1_q        <= '0;
            s1_mode     <= MODE_ADD;
            s1_tag      <= '0;
        end else if (s1_adv) begin
            vld_pipe[1] <= accept;
            if (accept) begin
                s1_r    <= raw;
                s1_q    <= q_sel;
                s1_mode <= mode_in;
                s1_tag  <= bus.in_tag;
            end
        end
    end

    assign q_ext = {1'b0, s1_q};

    always_comb begin
        c_next = s1_r[W-1:0];
        if (s1_mode == MODE_ADD) begin
            if (s1_r >= q_ext)
                c_next = W'(s1_r - q_ext);
        end else if (s1_r[W]) begin
            c_next = W'(s1_r + q_ext);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe[2] <= 1'b0;
            s2_c        <= '0;
            s2_tag      <= '0;
        end else if (s2_adv) begin
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1]) begin
                s2_c   <= c_next;
                s2_tag <= s1_tag;
            end
        end
    end

    assign bus.out_valid = vld_pipe[2];
    assign bus.out_c     = s2_c;
    assign bus.out_tag   = s2_tag;

`ifdef MOD_ADDSUB_RANGE_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (accept && (bus.in_a >= q_sel || bus.in_b >= q_sel))
            err_q <= 1'b1;
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Self-checking bench for mod_addsub_pipe: directed corner cases, reconfiguration,
// a randomized backpressured stream against a modular-arithmetic model, and reset.
module tb_mod_addsub_pipe;
    localparam int W = 30, IDX_W = 4, TAG_W = 8, NUM_MODS = 16;
    localparam longint DQ = 1073479681;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0, n_fail = 0;

    typedef struct { longint c; int tag; } exp_t;
    exp_t   expq[$];
    longint mq[NUM_MODS];
    int     midx;

    mod_addsub_pipe_if #(.W(W), .IDX_W(IDX_W), .TAG_W(TAG_W)) bus ();

    mod_addsub_pipe #(
        .W(W), .NUM_MODS(NUM_MODS), .IDX_W(IDX_W), .TAG_W(TAG_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint ref_c(input bit sub, input longint a, input longint b, input longint q);
        if (sub) return ((a - b) % q + q) % q;
        return (a + b) % q;
    endfunction

    function automatic void model_reset();
        foreach (mq[i]) mq[i] = DQ;
        midx = 0;
    endfunction

    // Offer one op with out_ready=1; result must be visible two cycles after the offer cycle.
    task automatic op1(input bit sub, input longint a, input longint b, input int tag,
                       input longint exp, input string nm);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_sub = sub; bus.in_a = W'(a); bus.in_b = W'(b);
        bus.in_tag = TAG_W'(tag); bus.out_ready = 1'b1;
        #1 chk(bus.in_ready, 1, {nm, " in_ready"});
        @(posedge clk); #1 bus.in_valid = 1'b0;
        chk(bus.out_valid, 0, {nm, " early"});
        @(posedge clk); #1;
        chk(bus.out_valid, 1, {nm, " valid"});
        chk(bus.out_c, exp, {nm, " c"});
        chk(bus.out_tag, tag, {nm, " tag"});
        @(posedge clk); #1 chk(bus.out_valid, 0, {nm, " drain"});
    endtask

    initial begin
        bit     exp_err;
        int     n_acc, n_del, cyc;
        bit     have, cs;
        longint ca, cb, q;
        exp_t   e;

`ifdef MOD_ADDSUB_RANGE_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        rst_n = 1'b0;
        bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_q = '0; bus.mod_sel = 0; bus.mod_index = '0;
        bus.in_valid = 0; bus.in_sub = 0; bus.in_a = '0; bus.in_b = '0; bus.in_tag = '0;
        bus.out_ready = 0;
        model_reset();
        #1;
        chk(bus.out_valid, 0, "rst out_valid");
        chk(bus.out_c, 0, "rst out_c");
        chk(bus.out_tag, 0, "rst out_tag");
        chk(bus.err, 0, "rst err");
        chk(bus.in_ready, 0, "rst in_ready");
        #20 @(negedge clk) rst_n = 1'b1;

        op1(1, 5, 7, 1, ref_c(1, 5, 7, DQ), "sub 5-7");
        op1(1, 7, 5, 2, 2, "sub 7-5");
        op1(0, DQ - 1, DQ - 1, 3, DQ - 2, "add max");
        op1(0, 3, DQ - 3, 4, 0, "add exact q");
        op1(1, 123, 123, 5, 0, "sub equal");

        // Table write, index switch and an accept on the same edge, then a twin op.
        @(negedge clk);
        bus.cfg_we = 1; bus.cfg_addr = 4'd3; bus.cfg_q = 30'd12289;
        bus.mod_sel = 1; bus.mod_index = 4'd3; bus.out_ready = 1;
        bus.in_valid = 1; bus.in_sub = 0; bus.in_a = 30'd12000; bus.in_b = 30'd300; bus.in_tag = 8'd10;
        @(negedge clk);
        bus.cfg_we = 0; bus.mod_sel = 0; bus.in_tag = 8'd11;
        mq[3] = 12289; midx = 3;
        @(negedge clk);
        bus.in_valid = 0;
        chk(bus.out_valid, 1, "reconf old valid");
        chk(bus.out_c, 12300, "reconf old q");
        chk(bus.out_tag, 10, "reconf old tag");
        @(negedge clk);
        chk(bus.out_valid, 1, "reconf new valid");
        chk(bus.out_c, 11, "reconf new q");
        chk(bus.out_tag, 11, "reconf new tag");

        @(negedge clk);
        bus.cfg_we = 1; bus.cfg_addr = 4'd5; bus.cfg_q = 30'd998244353;
        @(negedge clk);
        bus.cfg_we = 0; bus.mod_sel = 1; bus.mod_index = 4'd5;
        mq[5] = 998244353;
        @(negedge clk);
        bus.mod_sel = 0; midx = 5;

        // Random stream under random backpressure; occupancy predicts in_ready.
        n_acc = 0; n_del = 0; cyc = 0; have = 0; cs = 0; ca = 0; cb = 0;
        q = mq[midx];
        while (n_del < 100 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            bus.out_ready = ($urandom_range(0, 2) != 0);
            if (n_acc < 100) begin
                if (!have) begin
                    cs = 1'($urandom_range(0, 1));
                    ca = longint'($urandom_range(32'(q - 1), 0));
                    cb = longint'($urandom_range(32'(q - 1), 0));
                    have = 1;
                end
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.in_sub = cs; bus.in_a = W'(ca); bus.in_b = W'(cb); bus.in_tag = TAG_W'(n_acc);
            end else begin
                bus.in_valid = 0;
            end
            #2;
            chk(bus.in_ready, ((n_acc - n_del) < 2) || bus.out_ready, "stream in_ready");
            if (bus.out_valid && bus.out_ready) begin
                chk(expq.size() > 0, 1, "stream expected pending");
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    chk(bus.out_c, e.c, "stream c");
                    chk(bus.out_tag, e.tag, "stream tag");
                end
                n_del++;
            end
            if (bus.in_valid && bus.in_ready) begin
                expq.push_back('{ref_c(cs, ca, cb, q), n_acc});
                n_acc++;
                have = 0;
            end
        end
        chk(n_del, 100, "stream delivered");
        chk(n_acc, 100, "stream accepted");
        @(negedge clk);
        bus.in_valid = 0; bus.out_ready = 1;

        // Two ops parked in the pipe, then reset.
        @(negedge clk);
        bus.out_ready = 0; bus.in_valid = 1; bus.in_sub = 0; bus.in_a = 30'd1; bus.in_b = 30'd2; bus.in_tag = 8'd77;
        @(negedge clk);
        bus.in_tag = 8'd78;
        @(negedge clk);
        bus.in_valid = 0;
        chk(bus.out_valid, 1, "pre-rst full");
        rst_n = 1'b0;
        #1;
        chk(bus.out_valid, 0, "mid-rst out_valid");
        chk(bus.out_tag, 0, "mid-rst out_tag");
        chk(bus.in_ready, 0, "mid-rst in_ready");
        model_reset();
        @(negedge clk) rst_n = 1'b1; bus.out_ready = 1;
        repeat (4) begin
            @(posedge clk); #1 chk(bus.out_valid, 0, "post-rst stale");
        end
        op1(1, 5, 7, 20, ref_c(1, 5, 7, mq[midx]), "post-rst sub");
        chk(bus.err, 0, "err legal");

        // Operand equal to q is out of range.
        @(negedge clk);
        bus.in_valid = 1; bus.in_sub = 0; bus.in_a = W'(DQ); bus.in_b = '0; bus.in_tag = 8'd30;
        #1 chk(bus.err, 0, "err before accept");
        @(posedge clk); #1 bus.in_valid = 0;
        chk(bus.err, exp_err, "err set");
        repeat (5) @(posedge clk);
        #1 chk(bus.err, exp_err, "err sticky");
        chk(bus.out_valid, 0, "err drained");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
